ddr_cmd_sched: RTL and testbench
================================

# ddr_cmd_sched

Column-command scheduler between the controller's read and write request paths and the DDR command driver inside `DDR_TOP`. It picks one of RD, WR or REF each slot and enforces the spacing rules for each choice:
- tCCD between column commands in the same direction;
- write-to-read and read-to-write turnaround;
- read/write starvation limits;
- periodic refresh with postponement (up to 8 owed) and a tRFC blackout.

It presents one command at a time to the driver through a valid/ready handshake.

## Interface
Parameters:
- `tCCD`, 4: minimum cycles between same-direction column-command accepts.
- `tWTR`, 6: minimum cycles from a WR accept to the next RD accept.
- `tRTW`, 8: minimum cycles from a RD accept to the next WR accept.
- `tREFI`, 780: refresh interval in clocks.
- `tRFC`, 35: cycles after a REF accept during which no command is offered.
- `STARVE_LIMIT`, 8: maximum consecutive same-direction accepts while the other direction is waiting.

Ports:
- `clock` in 1: DDR controller clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `rd_req` in 1: read work pending; held high until granted.
- `wr_req` in 1: write work pending; held high until granted.
- `rd_gnt` out 1: one-cycle pulse when a RD is accepted.
- `wr_gnt` out 1: one-cycle pulse when a WR is accepted.
- `cmd_valid` out 1: a command is offered to the driver.
- `cmd_type` out 2: `ddr_cmd_e` (NOP=0, RD=1, WR=2, REF=3).
- `cmd_ready` in 1: driver accepts the command this cycle.
- `ref_owed` out 4: number of postponed refreshes, 0..8.

## Operation
- **Accept:** a command is accepted in a cycle where `cmd_valid && cmd_ready`.
  - `rd_gnt = accept && cmd_type==RD`; `wr_gnt = accept && cmd_type==WR`. Both are combinational from the registered outputs.
- **Registered outputs:** `cmd_valid`, `cmd_type` and `ref_owed` are registered.
  - While `cmd_valid=1 && cmd_ready=0`, `cmd_type` is held stable. No re-arbitration happens, and a newly owed refresh does not pre-empt the stalled command.
- **Counters:**
  - `since` counts clocks since the last accept. It is 0 in the accept cycle and saturates at max(tRTW, tWTR, tCCD).
  - `last_dir` records the direction of the last column command (RD/WR).
  - `run` counts consecutive same-direction accepts.
- **State machine:** states IDLE, OFFER and RFC_WAIT.
  - **IDLE:** evaluated every cycle, with decisions made in priority order.
    1. If `ref_owed>0` and `since>=tRTW` and `since>=tWTR`, go to OFFER with REF.
    2. Otherwise pick a direction:
       - prefer `last_dir` if its request is high;
       - take the other direction if only it is requesting;
       - take the other direction if both are requesting and `run>=STARVE_LIMIT`.
    3. Offer the chosen direction only when `since` ≥ its gap: tCCD for the same direction, tWTR for WR→RD, tRTW for RD→WR.
  - **OFFER:** `cmd_valid=1`.
    - On accept: update `last_dir` and `run` for column commands; a direction change resets `run` to 1.
    - Then go to IDLE, or to RFC_WAIT if the command was REF.
  - **RFC_WAIT:** `cmd_valid=0` for tRFC cycles after the REF accept, then go to IDLE.
- **Refresh timer:** free-running from reset.
  - Each tREFI expiry increments `ref_owed`, saturating at 8.
  - A REF accept decrements it.
  - If an expiry and a REF accept fall in the same cycle, the count is unchanged.
- **Reset (asynchronous, any state):**
  - `cmd_valid=0`, `cmd_type=NOP`, `ref_owed=0`, state IDLE.
  - `last_dir=RD`, `run=0`, `since` saturated, refresh timer=0.
  - Grants are 0 as a consequence.

## Timing
- Decision-to-valid latency is 1 clock.
  - With `cmd_ready` tied high, a command accepted at cycle N is followed by the next accept at exactly N+gap, provided the request is held and no refresh is owed.
- After reset release with a request high, `cmd_valid` rises after the first rising edge at which `reset_n=1`.
- The first REF is owed at cycle tREFI after reset release.
- A REF accepted at cycle N gives a next-command accept no earlier than N+tRFC+1.
- `rd_req`/`wr_req` are sampled only in IDLE. A request dropped while its command is in OFFER does not cancel the command.

## Structure
- `ddr_package` holds:
  - `typedef enum logic [1:0] ddr_cmd_e`;
  - the scheduler state enum;
  - `localparam REF_OWED_MAX = 8`.
- Sub-module `ddr_ref_timer`: tREFI counter plus the saturating `ref_owed` up/down counter. Interface: inputs `ref_done`; outputs `ref_owed`.
- The remainder is one FSM with the `since`, `run` and `last_dir` registers.

## Test plan
- **Reset and back-to-back writes:** `wr_req=1`, `cmd_ready=1`, default parameters → WR accepts at N, N+4, N+8, N+12; `wr_gnt` pulses once per accept.
- **Turnaround:**
  - WR accepted at N, then only `rd_req` → RD accepted at N+6.
  - RD accepted at M, then only `wr_req` → WR accepted at M+8.
- **Starvation:** `STARVE_LIMIT=4`, both requests held high → 4 RD, then WR at last RD+8, 4 WR, then RD at last WR+6.
- **Refresh:** `tREFI=100`, `tRFC=35`, continuous writes → REF offered once `since>=8` after `ref_owed` becomes 1; no `cmd_valid` for 35 cycles after the REF accept; `ref_owed` returns to 0.
- **Backpressure and owed-refresh saturation:**
  - `cmd_ready=0` for 9×tREFI while WR is offered → `cmd_type` stays WR, no grants, `ref_owed` saturates at 8.
  - Raise `cmd_ready` → WR accepted, then 8 REFs, each separated by tRFC.
- **Reset during RFC_WAIT:** assert `reset_n=0` mid-blackout → outputs go to reset values immediately with no clock edge; after release, the first REF is again owed at tREFI.

Source files
------------

// File: rtl/ddr_package.sv
// Shared types for the DDR column-command scheduler.
//   ddr_cmd_e     : command encoding presented to the DDR command driver
//   sched_state_e : scheduler FSM states
//   REF_OWED_MAX  : ceiling on postponed refreshes
package ddr_package;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    RD  = 2'd1,
    WR  = 2'd2,
    REF = 2'd3
  } ddr_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_RFC_WAIT
  } sched_state_e;

  localparam int unsigned REF_OWED_MAX = 8;
  localparam int unsigned REF_OWED_W   = 4;

  // Largest of three timing gaps; sets the saturation point of the spacing counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddr_ref_timer.sv
// Refresh interval timer with a saturating count of owed refreshes.
//   clock, reset_n : clock, async active-low reset
//   ref_done       : a REF was accepted by the driver this cycle
//   ref_owed       : registered count of postponed refreshes, 0..REF_OWED_MAX
module ddr_ref_timer
  import ddr_package::*;
#(
  parameter int unsigned tREFI = 780
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ref_done,
  output logic [REF_OWED_W-1:0] ref_owed
);

  localparam int unsigned TW = $clog2(tREFI + 1);

  logic [TW-1:0]         tick_q, tick_d;
  logic [REF_OWED_W-1:0] ref_owed_q, ref_owed_d;
  logic                  expire;

  // Free-running interval counter; an expiry and a REF accept in the same cycle cancel out.
  always_comb begin
    expire     = (tick_q == TW'(tREFI - 1));
    tick_d     = expire ? '0 : tick_q + TW'(1);
    ref_owed_d = ref_owed_q;
    if (expire && !ref_done) begin
      if (ref_owed_q != REF_OWED_W'(REF_OWED_MAX)) ref_owed_d = ref_owed_q + REF_OWED_W'(1);
    end else if (ref_done && !expire) begin
      if (ref_owed_q != '0) ref_owed_d = ref_owed_q - REF_OWED_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_q     <= '0;
      ref_owed_q <= '0;
    end else begin
      tick_q     <= tick_d;
      ref_owed_q <= ref_owed_d;
    end
  end

  assign ref_owed = ref_owed_q;

endmodule

// File: rtl/ddr_cmd_sched.sv
// Column-command scheduler: picks RD, WR or REF and enforces tCCD, turnaround,
// starvation and refresh/tRFC spacing before offering one command to the driver.
//   clock, reset_n   : clock, async active-low reset
//   rd_req, wr_req   : pending read / write work, held until granted
//   rd_gnt, wr_gnt   : combinational accept pulses for RD / WR
//   cmd_valid/type   : registered command offer (ddr_cmd_e encoding)
//   cmd_ready        : driver accepts the offered command
//   ref_owed         : registered count of postponed refreshes
module ddr_cmd_sched
  import ddr_package::*;
#(
  parameter int unsigned tCCD         = 4,
  parameter int unsigned tWTR         = 6,
  parameter int unsigned tRTW         = 8,
  parameter int unsigned tREFI        = 780,
  parameter int unsigned tRFC         = 35,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  rd_req,
  input  logic                  wr_req,
  output logic                  rd_gnt,
  output logic                  wr_gnt,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  input  logic                  cmd_ready,
  output logic [REF_OWED_W-1:0] ref_owed
);

  localparam int unsigned SINCE_MAX = max3(tCCD, tWTR, tRTW);
  localparam int unsigned SW        = $clog2(SINCE_MAX + 1);
  localparam int unsigned RUNW      = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned RFCW      = $clog2(tRFC + 1);

  sched_state_e    state_q, state_d;
  logic            cmd_valid_q, cmd_valid_d;
  ddr_cmd_e        cmd_type_q, cmd_type_d;
  ddr_cmd_e        last_dir_q, last_dir_d;
  logic [SW-1:0]   since_q, since_d;
  logic [RUNW-1:0] run_q, run_d;
  logic [RFCW-1:0] rfc_cnt_q, rfc_cnt_d;

  logic            accept, ref_done;
  logic [SW-1:0]   since_nx, gap;
  logic            same_req, other_req, pick_v;
  ddr_cmd_e        other_dir, pick;

  assign accept   = cmd_valid_q && cmd_ready;
  assign ref_done = accept && (cmd_type_q == REF);
  assign rd_gnt   = accept && (cmd_type_q == RD);
  assign wr_gnt   = accept && (cmd_type_q == WR);

  assign cmd_valid = cmd_valid_q;
  assign cmd_type  = cmd_type_q;

  ddr_ref_timer #(
    .tREFI(tREFI)
  ) u_ref_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .ref_done (ref_done),
    .ref_owed (ref_owed)
  );

  // Next-state and offer logic. since_q is the distance from the last accept to the
  // current cycle; since_nx is that distance for a command offered at the next edge,
  // which is what the gap rules must be checked against.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    cmd_type_d  = cmd_type_q;
    last_dir_d  = last_dir_q;
    run_d       = run_q;
    rfc_cnt_d   = rfc_cnt_q;
    since_nx    = (since_q == SW'(SINCE_MAX)) ? since_q : since_q + SW'(1);
    since_d     = accept ? SW'(1) : since_nx;

    other_dir = (last_dir_q == RD) ? WR : RD;
    same_req  = (last_dir_q == RD) ? rd_req : wr_req;
    other_req = (last_dir_q == RD) ? wr_req : rd_req;
    pick_v    = 1'b0;
    pick      = last_dir_q;
    gap       = SW'(tCCD);

    // Stay in the current direction unless the other side has waited through a full run.
    if (same_req && !(other_req && (run_q >= RUNW'(STARVE_LIMIT)))) begin
      pick_v = 1'b1;
    end else if (other_req) begin
      pick_v = 1'b1;
      pick   = other_dir;
      gap    = (last_dir_q == WR) ? SW'(tWTR) : SW'(tRTW);
    end

    unique case (state_q)
      ST_IDLE: begin
        // An owed refresh blocks column traffic until both turnarounds have drained.
        if (ref_owed != '0) begin
          if ((since_nx >= SW'(tRTW)) && (since_nx >= SW'(tWTR))) begin
            state_d     = ST_OFFER;
            cmd_valid_d = 1'b1;
            cmd_type_d  = REF;
          end
        end else if (pick_v && (since_nx >= gap)) begin
          state_d     = ST_OFFER;
          cmd_valid_d = 1'b1;
          cmd_type_d  = pick;
        end
      end
      ST_OFFER: begin
        // Offer is held unchanged until the driver takes it.
        if (accept) begin
          cmd_valid_d = 1'b0;
          cmd_type_d  = NOP;
          if (cmd_type_q == REF) begin
            state_d   = ST_RFC_WAIT;
            rfc_cnt_d = RFCW'(tRFC - 1);
          end else begin
            state_d    = ST_IDLE;
            last_dir_d = cmd_type_q;
            if (cmd_type_q != last_dir_q) run_d = RUNW'(1);
            else if (run_q != '1)         run_d = run_q + RUNW'(1);
          end
        end
      end
      ST_RFC_WAIT: begin
        if (rfc_cnt_q == '0) state_d = ST_IDLE;
        else                 rfc_cnt_d = rfc_cnt_q - RFCW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= NOP;
      last_dir_q  <= RD;
      run_q       <= '0;
      since_q     <= SW'(SINCE_MAX);
      rfc_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      last_dir_q  <= last_dir_d;
      run_q       <= run_d;
      since_q     <= since_d;
      rfc_cnt_q   <= rfc_cnt_d;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_sched.sv
// Scoreboard bench for ddr_cmd_sched with tREFI=100 and STARVE_LIMIT=4.
// Expected accepts (cycle, type) are queued as stimulus is applied and popped as the
// driver side accepts commands. Cycle 0 is the cycle in which reset is released.
module tb_ddr_cmd_sched;
  import ddr_package::*;

  localparam int T_REFI = 100;
  localparam int T_RFC  = 35;

  typedef struct {
    int         cyc;
    logic [1:0] typ;
  } exp_t;

  logic       clock;
  logic       reset_n;
  logic       rd_req, wr_req, cmd_ready;
  logic       rd_gnt, wr_gnt, cmd_valid;
  logic [1:0] cmd_type;
  logic [3:0] ref_owed;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks, n_errors;
  int   rd_left, wr_left;
  int   stray;
  int   last_ref;
  bit   ref_seen;

  ddr_cmd_sched #(
    .tCCD(4), .tWTR(6), .tRTW(8), .tREFI(T_REFI), .tRFC(T_RFC), .STARVE_LIMIT(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .rd_req    (rd_req),
    .wr_req    (wr_req),
    .rd_gnt    (rd_gnt),
    .wr_gnt    (wr_gnt),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_ready (cmd_ready),
    .ref_owed  (ref_owed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [1:0] t);
    exp_t e;
    e.cyc = c;
    e.typ = t;
    exp_q.push_back(e);
  endtask

  // One clock: monitor at the falling edge, return just after the next rising edge.
  task automatic step();
    exp_t e;
    @(negedge clock);
    if (reset_n) begin
      if (cmd_valid && cmd_ready) begin
        check("acc_queued", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("acc_cyc",  32'(cyc),      32'(e.cyc));
          check("acc_type", 32'(cmd_type), 32'(e.typ));
          check("rd_gnt",   32'(rd_gnt),   32'(e.typ == RD));
          check("wr_gnt",   32'(wr_gnt),   32'(e.typ == WR));
        end
        if (cmd_type == REF) begin
          ref_seen = 1'b1;
          last_ref = cyc;
        end
      end else if (rd_gnt || wr_gnt) begin
        stray++;
      end
      if (rd_gnt && rd_left > 0) begin
        rd_left--;
        if (rd_left == 0) rd_req = 1'b0;
      end
      if (wr_gnt && wr_left > 0) begin
        wr_left--;
        if (wr_left == 0) wr_req = 1'b0;
      end
      if (ref_seen && cyc > last_ref && cyc <= last_ref + T_RFC)
        check("rfc_blackout", 32'(cmd_valid), 32'(0));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic step_to(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'(0));
  endtask

  task automatic do_reset(input logic rd, input logic wr, input logic rdy,
                          input int rl, input int wl);
    reset_n   = 1'b0;
    rd_req    = rd;
    wr_req    = wr;
    cmd_ready = rdy;
    rd_left   = rl;
    wr_left   = wl;
    #1;
    check("rst_valid",  32'(cmd_valid), 32'(0));
    check("rst_type",   32'(cmd_type),  32'(NOP));
    check("rst_owed",   32'(ref_owed),  32'(0));
    check("rst_rd_gnt", 32'(rd_gnt),    32'(0));
    check("rst_wr_gnt", 32'(wr_gnt),    32'(0));
    exp_q.delete();
    ref_seen = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    stray     = 0;
    last_ref  = 0;
    ref_seen  = 1'b0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    cmd_ready = 1'b0;
    rd_left   = 0;
    wr_left   = 0;
    reset_n   = 1'b1;
    #2;

    // Back-to-back writes at tCCD spacing.
    do_reset(1'b0, 1'b1, 1'b1, 0, 4);
    push(1, WR); push(5, WR); push(9, WR); push(13, WR);
    wait_drain(40);

    // WR->RD turnaround, then RD->WR turnaround.
    push(19, RD);
    rd_req = 1'b1; rd_left = 1;
    wait_drain(20);
    push(27, WR);
    wr_req = 1'b1; wr_left = 1;
    wait_drain(20);

    // Starvation: 4 RD, WR after tRTW, 4 WR, RD after tWTR.
    do_reset(1'b1, 1'b1, 1'b1, 5, 4);
    push(1, RD); push(5, RD); push(9, RD); push(13, RD);
    push(21, WR); push(25, WR); push(29, WR); push(33, WR);
    push(39, RD);
    wait_drain(60);

    // Refresh interleaved with continuous writes.
    do_reset(1'b0, 1'b1, 1'b1, 0, 28);
    for (int k = 0; k < 25; k++) push(1 + 4 * k, WR);
    push(105, REF);
    push(142, WR); push(146, WR); push(150, WR);
    step_to(99);
    check("owed_before_refi", 32'(ref_owed), 32'(0));
    step_to(100);
    check("owed_at_refi", 32'(ref_owed), 32'(1));
    step_to(106);
    check("owed_after_ref", 32'(ref_owed), 32'(0));
    wait_drain(80);

    // Backpressure: stalled WR holds while owed refreshes saturate, then drains.
    do_reset(1'b0, 1'b1, 1'b0, 0, 1);
    step_to(150);
    check("stall_valid", 32'(cmd_valid), 32'(1));
    check("stall_type",  32'(cmd_type),  32'(WR));
    check("stall_gnt",   32'(wr_gnt),    32'(0));
    check("stall_owed1", 32'(ref_owed),  32'(1));
    step_to(450);
    check("stall_owed4", 32'(ref_owed),  32'(4));
    step_to(850);
    check("stall_owed8", 32'(ref_owed),  32'(8));
    step_to(905);
    check("sat_owed",    32'(ref_owed),  32'(8));
    check("sat_type",    32'(cmd_type),  32'(WR));
    push(905, WR);
    for (int i = 0; i < 8; i++) push(913 + 37 * i, REF);
    cmd_ready = 1'b1;
    step_to(1190);
    wait_drain(1);
    check("owed_mid_rfc", 32'(ref_owed), 32'(2));

    // Reset mid-blackout; refresh timer restarts from zero.
    do_reset(1'b0, 1'b0, 1'b1, 0, 0);
    step_to(99);
    check("rerst_owed99", 32'(ref_owed), 32'(0));
    push(101, REF);
    step_to(100);
    check("rerst_owed100", 32'(ref_owed), 32'(1));
    wait_drain(10);
    check("rerst_owed_done", 32'(ref_owed), 32'(0));

    check("stray_gnt", 32'(stray), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
